// File: rtl/dram_host_port_ctrl.sv
// Host-side sequencer for the DRAM file port: load an image, run the cores,
// then stream a result window back to the host.
module dram_host_port_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_CORES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    load_base,
  input  logic [ADDR_W:0]      load_len,
  input  logic [ADDR_W-1:0]    dump_base,
  input  logic [ADDR_W:0]      dump_len,
  input  logic [2:0]           no_Cores,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic [MAX_CORES-1:0] core_end,
  output logic [MAX_CORES-1:0] core_enable,
  output logic [DATA_W-1:0]    dataIn_file,
  output logic [ADDR_W-1:0]    addr_file,
  output logic                 we_file,
  input  logic [DATA_W-1:0]    dataOut_file,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, DUMP_RD, DUMP_OUT, DONE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [ADDR_W-1:0]    addr_cnt;
  logic [CW-1:0]        word_cnt;
  logic [ADDR_W-1:0]    dump_base_q;
  logic [CW-1:0]        dump_len_q;
  logic [MAX_CORES-1:0] en_mask;
  logic [MAX_CORES-1:0] start_mask;
  logic [DATA_W-1:0]    out_q;
  logic                 fresh;
  logic                 idle_like;
  logic                 load_hs;
  logic                 dump_hs;
  logic                 last_word;
  logic                 run_exit;
  int                   eff;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign load_hs   = (state == LOAD) && in_valid;
  assign dump_hs   = (state == DUMP_OUT) && out_ready;
  assign last_word = (word_cnt == CW'(1));
  assign run_exit  = (state == RUN) &&
                     ((core_end & en_mask) == en_mask);

  // Effective core count: 0 means one core, above MAX_CORES clamps.
  always_comb begin
    eff = 32'(no_Cores);
    if (eff == 0) eff = 1;
    if (eff > MAX_CORES) eff = MAX_CORES;
    start_mask = '0;
    for (int i = 0; i < MAX_CORES; i++) begin
      start_mask[i] = (i < eff);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state sequencing.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nx = (load_len == '0) ? RUN : LOAD;
      end
      LOAD: begin
        if (load_hs && last_word) state_nx = RUN;
      end
      RUN: begin
        if (run_exit) state_nx = (dump_len_q == '0) ? DONE : DUMP_RD;
      end
      DUMP_RD: state_nx = DUMP_OUT;
      DUMP_OUT: begin
        if (dump_hs) state_nx = last_word ? DONE : DUMP_RD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counters, file-port registers and read-data holding register.
  // addr_file is loaded on entry to DUMP_RD so the DRAM sees the read
  // address for the whole DUMP_RD cycle; its data arrives in the first
  // DUMP_OUT cycle and is passed straight through, then held in out_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt    <= '0;
      word_cnt    <= '0;
      dump_base_q <= '0;
      dump_len_q  <= '0;
      en_mask     <= '0;
      out_q       <= '0;
      fresh       <= 1'b0;
      we_file     <= 1'b0;
      addr_file   <= '0;
      dataIn_file <= '0;
    end else begin
      we_file <= 1'b0;
      fresh   <= (state == DUMP_RD);
      if (fresh) out_q <= dataOut_file;
      if (idle_like && start) begin
        addr_cnt    <= load_base;
        word_cnt    <= load_len;
        dump_base_q <= dump_base;
        dump_len_q  <= dump_len;
        en_mask     <= start_mask;
      end
      if (load_hs) begin
        we_file     <= 1'b1;
        addr_file   <= addr_cnt;
        dataIn_file <= in_data;
        addr_cnt    <= addr_cnt + ADDR_W'(1);
        word_cnt    <= word_cnt - CW'(1);
      end
      if (run_exit) begin
        addr_cnt <= dump_base_q;
        word_cnt <= dump_len_q;
        if (dump_len_q != '0) addr_file <= dump_base_q;
      end
      if (dump_hs) begin
        addr_cnt <= addr_cnt + ADDR_W'(1);
        word_cnt <= word_cnt - CW'(1);
        if (!last_word) addr_file <= addr_cnt + ADDR_W'(1);
      end
    end
  end

  // State-decoded outputs.
  always_comb begin
    in_ready    = (state == LOAD);
    out_valid   = (state == DUMP_OUT);
    core_enable = (state == RUN) ? en_mask : '0;
    busy        = !idle_like;
    done        = (state == DONE);
    out_data    = fresh ? dataOut_file : out_q;
  end

endmodule

// File: tb/tb_dram_host_port_ctrl.sv
// Directed bench for dram_host_port_ctrl with a small
// synchronous-read DRAM model on the file port.
module tb_dram_host_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] load_base = '0;
  logic [12:0] load_len = '0;
  logic [11:0] dump_base = '0;
  logic [12:0] dump_len = '0;
  logic [2:0]  no_Cores = '0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  core_end = '0;
  logic [3:0]  core_enable;
  logic [31:0] dataIn_file;
  logic [11:0] addr_file;
  logic        we_file;
  logic [31:0] dataOut_file = '0;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:4095];
  logic [11:0] wa[$];
  logic [31:0] wd[$];

  dram_host_port_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .load_base(load_base), .load_len(load_len),
    .dump_base(dump_base), .dump_len(dump_len),
    .no_Cores(no_Cores),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .core_end(core_end), .core_enable(core_enable),
    .dataIn_file(dataIn_file), .addr_file(addr_file),
    .we_file(we_file), .dataOut_file(dataOut_file),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // DRAM: registered write, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (we_file) mem[addr_file] <= dataIn_file;
    dataOut_file <= mem[addr_file];
  end

  // Log every write pulse seen on the file port.
  always @(negedge clk) begin
    if (we_file) begin
      wa.push_back(addr_file);
      wd.push_back(dataIn_file);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic kick(input logic [11:0] lb, input logic [12:0] ll,
                      input logic [11:0] db, input logic [12:0] dl,
                      input logic [2:0] nc);
    load_base = lb;
    load_len  = ll;
    dump_base = db;
    dump_len  = dl;
    no_Cores  = nc;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic clr_log();
    wa.delete();
    wd.delete();
  endtask

  logic [31:0] wv [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wv = '{32'hA, 32'hB, 32'hC};
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_we", we_file, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", core_enable, 0);
    chk("rst_addr", addr_file, 0);
    chk("rst_din", dataIn_file, 0);
    chk("rst_dout", out_data, 0);
    rst_n = 1'b1;
    step();

    // A: load 3 words at 0x010, two cores, dump them back.
    kick(12'h010, 13'd3, 12'h010, 13'd3, 3'd2);
    for (int k = 0; k < 3; k++) begin
      chk("a_in_ready", in_ready, 1);
      in_data  = wv[k];
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("a_ready_drop", in_ready, 0);
    chk("a_busy", busy, 1);
    chk("a_en", core_enable, 4'b0011);
    core_end = 4'b0001;
    step();
    step();
    chk("a_run_hold", core_enable, 4'b0011);
    chk("a_run_done", done, 0);
    core_end = 4'b0011;
    step();
    core_end = 4'b0000;
    chk("a_en_off", core_enable, 0);
    for (int k = 0; k < 3; k++) begin
      chk("a_rd_addr", addr_file, 12'h010 + 12'(k));
      chk("a_rd_valid", out_valid, 0);
      chk("a_rd_we", we_file, 0);
      step();
      chk("a_ov1", out_valid, 1);
      chk("a_od1", out_data, wv[k]);
      out_ready = 1'b0;
      step();
      chk("a_ov_hold", out_valid, 1);
      chk("a_od_hold", out_data, wv[k]);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("a_done", done, 1);
    chk("a_busy_end", busy, 0);
    chk("a_wr_cnt", wa.size(), 3);
    if (wa.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("a_wr_addr", wa[k], 12'h010 + 12'(k));
        chk("a_wr_data", wd[k], wv[k]);
      end
    end
    clr_log();

    // B: address wrap, core count clamp, no dump.
    kick(12'hFFF, 13'd2, 12'h000, 13'd0, 3'd7);
    chk("b_done_clr", done, 0);
    for (int k = 0; k < 2; k++) begin
      chk("b_in_ready", in_ready, 1);
      in_data  = 32'h11 * 32'(k + 1);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("b_ready_drop", in_ready, 0);
    chk("b_en_clamp", core_enable, 4'b1111);
    core_end = 4'b1111;
    step();
    core_end = 4'b0000;
    chk("b_done", done, 1);
    chk("b_en_off", core_enable, 0);
    step();
    chk("b_wr_cnt", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("b_wr_a0", wa[0], 12'hFFF);
      chk("b_wr_a1", wa[1], 12'h000);
      chk("b_wr_d0", wd[0], 32'h11);
      chk("b_wr_d1", wd[1], 32'h22);
    end
    clr_log();

    // C: zero-length load and dump, zero cores -> one core.
    kick(12'h050, 13'd0, 12'h060, 13'd0, 3'd0);
    chk("c_en", core_enable, 4'b0001);
    chk("c_in_ready", in_ready, 0);
    chk("c_busy", busy, 1);
    core_end = 4'b1110;
    step();
    step();
    chk("c_en_hold", core_enable, 4'b0001);
    core_end = 4'b0001;
    step();
    core_end = 4'b0000;
    chk("c_done", done, 1);
    step();
    chk("c_no_wr", wa.size(), 0);
    clr_log();

    // E: start ignored while busy, then reset mid-load.
    kick(12'h100, 13'd4, 12'h000, 13'd0, 3'd1);
    in_data  = 32'h31;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    kick(12'h300, 13'd0, 12'h000, 13'd0, 3'd1);
    chk("e_busy_start", in_ready, 1);
    chk("e_busy", busy, 1);
    in_data  = 32'h32;
    in_valid = 1'b1;
    step();
    in_data  = 32'h33;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_rst_we", we_file, 0);
    chk("e_rst_addr", addr_file, 0);
    chk("e_rst_din", dataIn_file, 0);
    chk("e_rst_ready", in_ready, 0);
    chk("e_rst_busy", busy, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("e_idle_ready", in_ready, 0);
    in_valid = 1'b0;
    chk("e_wr_cnt", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("e_wr_a1", wa[1], 12'h101);
      chk("e_wr_d1", wd[1], 32'h32);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
